// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, key-schedule FSM encoding and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR = 10;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_EXPAND = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    // Round constant for the round key being generated (1..10)
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] v;
        case (round)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box (GF(2^8) inverse + affine map).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] c_INV_EXP = 8'd254;
    localparam logic [7:0] c_AFFINE  = 8'h63;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (c_INV_EXP[i]) r = gf_mul(r, s);
            s = gf_mul(s, s);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv  = gf_inv(i_byte);
        o_byte = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ c_AFFINE;
    end

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule
// Description : AES-128 key expansion, one round key per clock, with a
//               registered read port serving the stored schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] Key,
    input  logic [3:0]   SelKey,
    output logic [127:0] RoundKey,
    output logic         Busy,
    output logic         KeyRy
);

    localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);

    generate
        if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
            $error("aes_key_schedule supports only NUM_ROUNDS = 10");
        end
    endgenerate

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic         w_accept;
    logic         w_expand;
    logic         w_read_ok;
    logic [3:0]   r_round;
    logic [127:0] r_work;
    logic [127:0] r_round_key;
    logic [127:0] r_buf [0:NUM_ROUNDS];
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [127:0] w_next_key;

    assign w_rot = rot_word(r_work[31:0]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        w_t                = w_sub ^ {rcon(r_round), 24'h000000};
        w_next_key[127:96] = r_work[127:96] ^ w_t;
        w_next_key[95:64]  = r_work[95:64]  ^ w_next_key[127:96];
        w_next_key[63:32]  = r_work[63:32]  ^ w_next_key[95:64];
        w_next_key[31:0]   = r_work[31:0]   ^ w_next_key[63:32];
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (Start) begin
                    w_next_state = c_ST_EXPAND;
                    w_accept     = 1'b1;
                end
            end
            c_ST_EXPAND: begin
                if (r_round == c_LAST_ROUND) w_next_state = c_ST_DONE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    assign w_expand = (r_state == c_ST_EXPAND);
    // A restarting edge already hides the old schedule
    assign w_read_ok = (r_state == c_ST_DONE) && !w_accept && (SelKey <= c_LAST_ROUND);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= c_ST_IDLE;
            r_round     <= 4'd0;
            r_work      <= '0;
            r_round_key <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_work  <= Key;
                r_round <= 4'd1;
            end else if (w_expand) begin
                r_work  <= w_next_key;
                r_round <= r_round + 4'd1;
            end
            r_round_key <= w_read_ok ? r_buf[SelKey] : '0;
        end
    end

    // Buffer is never readable outside DONE, so it needs no reset
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_buf[0] <= Key;
        end else if (w_expand) begin
            r_buf[r_round] <= w_next_key;
        end
    end

    assign RoundKey = r_round_key;
    assign Busy     = w_expand;
    assign KeyRy    = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_schedule
// Description : Self-checking bench for aes_key_schedule using FIPS-197 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;

    logic         Clk;
    logic         Rst;
    logic         Start;
    logic [127:0] Key;
    logic [3:0]   SelKey;
    logic [127:0] RoundKey;
    logic         Busy;
    logic         KeyRy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] a1 [0:10];
    logic [127:0] c1 [0:10];
    logic [127:0] exp_q [$];

    aes_key_schedule #(.NUM_ROUNDS(10)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Key      (Key),
        .SelKey   (SelKey),
        .RoundKey (RoundKey),
        .Busy     (Busy),
        .KeyRy    (KeyRy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, ".busy"}, {127'd0, Busy}, 128'd0);
        check_value({tag, ".keyry"}, {127'd0, KeyRy}, 128'd0);
        check_value({tag, ".rk"}, RoundKey, 128'd0);
    endtask

    // Read request goes out on a negedge; the expectation is queued and
    // retired against RoundKey just after the following posedge.
    task automatic do_read(input logic [3:0] sel, input logic [127:0] exp);
        @(negedge Clk);
        SelKey = sel;
        exp_q.push_back(exp);
        @(posedge Clk);
        #1;
        check_value($sformatf("rk[%0d]", sel), RoundKey, exp_q.pop_front());
    endtask

    task automatic start_key(input logic [127:0] k);
        @(negedge Clk);
        Key   = k;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Key   = ~k;
        check_value("e0.busy", {127'd0, Busy}, 128'd1);
        check_value("e0.keyry", {127'd0, KeyRy}, 128'd0);
    endtask

    // Walks edges E1..E10; injects a Start with another key at edge inject_at
    task automatic wait_done(input int inject_at, input logic [127:0] junk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            SelKey = 4'(i);
            exp_q.push_back(128'd0);
            if (i == inject_at) begin
                Start = 1'b1;
                Key   = junk;
            end
            @(posedge Clk);
            #1;
            Start = 1'b0;
            check_value($sformatf("busyread e%0d", i), RoundKey, exp_q.pop_front());
            if (i < 10) begin
                check_value($sformatf("busy e%0d", i), {127'd0, Busy}, 128'd1);
                check_value($sformatf("keyry e%0d", i), {127'd0, KeyRy}, 128'd0);
            end else begin
                check_value("busy e10", {127'd0, Busy}, 128'd0);
                check_value("keyry e10", {127'd0, KeyRy}, 128'd1);
            end
        end
    endtask

    task automatic sweep_a1;
        for (int r = 10; r >= 0; r--) do_read(4'(r), a1[r]);
    endtask

    task automatic sweep_c1;
        for (int r = 10; r >= 0; r--) do_read(4'(r), c1[r]);
    endtask

    initial begin
        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        c1[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        c1[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        c1[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        c1[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        c1[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        c1[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        c1[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        c1[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        c1[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        c1[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        c1[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        Rst    = 1'b1;
        Start  = 1'b0;
        Key    = '0;
        SelKey = '0;
        repeat (2) @(posedge Clk);
        #1;
        check_idle_outputs("reset");
        @(negedge Clk);
        Rst = 1'b0;
        do_read(4'd0, 128'd0);

        // A.1 with a Start carrying the C.1 key pulsed at E5
        start_key(a1[0]);
        wait_done(5, c1[0]);
        do_read(4'd1, a1[1]);
        do_read(4'd10, a1[10]);
        do_read(4'd0, a1[0]);
        do_read(4'd11, 128'd0);
        do_read(4'd15, 128'd0);
        sweep_a1();

        // Restart from DONE with C.1
        start_key(c1[0]);
        wait_done(0, 128'd0);
        sweep_c1();
        do_read(4'd12, 128'd0);

        // Asynchronous reset between E3 and E4
        start_key(a1[0]);
        repeat (3) @(posedge Clk);
        #3;
        Rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(posedge Clk);
        #1;
        check_idle_outputs("rst_hold");
        @(negedge Clk);
        Rst = 1'b0;
        do_read(4'd0, 128'd0);

        start_key(a1[0]);
        wait_done(0, 128'd0);
        sweep_a1();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/aes_key_schedule.md
# aes_key_schedule

AES-128 key-expansion stage sitting directly upstream of the inverse-cipher state machine. On a start pulse it expands a 128-bit cipher key into the 11 round keys (FIPS-197 §5.2), one round key per clock. It stores them in an internal buffer and serves them through a registered read port indexed by the decryptor's 4-bit `SelKey`. Decryption consumes keys in reverse order (10 down to 0), so the full schedule must be complete before `KeyRy` is raised.

## Interface
- `NUM_ROUNDS`, default 10: number of cipher rounds. Only 10 (AES-128) is supported; other values are a synthesis-time error.
- `Clk` input 1: sole clock; all state updates on rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `Start` input 1: request expansion of `Key`. Sampled only in IDLE or DONE.
- `Key` input 128: cipher key. `Key[127:120]` is key byte 0; word w0 = `Key[127:96]`. Sampled only on the accepting edge.
- `SelKey` input 4: round-key index to read, 0..10.
- `RoundKey` output 128: registered round key for the `SelKey` presented on the previous edge. Same byte order as `Key`.
- `Busy` output 1: expansion in progress.
- `KeyRy` output 1: all 11 round keys valid; held until restart or reset.

## Operation
- Reset values: state IDLE, round counter 0, `Busy`=0, `KeyRy`=0, `RoundKey`=0, working register 0, buffer contents don't-care but unreadable (gated by `KeyRy`).
- FSM states: IDLE, EXPAND, DONE.
  - IDLE, `Start`=1 → EXPAND. Write `Key` to buffer[0] and to the working register; counter←1; `Busy`←1.
  - EXPAND: each edge computes the next key from the working register and writes it to buffer[counter] and the working register; counter←counter+1. When counter=10 is written, go to DONE with `Busy`←0 and `KeyRy`←1.
  - DONE, `Start`=1 → EXPAND with the same actions as from IDLE; `KeyRy`←0 on that edge.
  - `Start` in EXPAND is ignored; no queueing.
- Next-key rule (w0..w3 = working register words, MSW first):
  - t = SubWord(RotWord(w3)) ^ {Rcon[counter],24'h0}
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. All XOR, no carries.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Read port: when `KeyRy`=1 and `SelKey`≤10, `RoundKey`←buffer[`SelKey`] each edge. Otherwise `RoundKey`←0 (`SelKey` 11..15, or `KeyRy`=0).
- Reset mid-expansion: immediate return to IDLE, all outputs as reset. A partial schedule is never exposed.

## Timing
- Start accepted at edge E0; buffer[r] written at edge E0+r; `KeyRy` high after E10 (10 cycles after acceptance, 11 edges including E0).
- `Busy` high after E0 through E10, low after E10; `Busy` and `KeyRy` are never both high.
- Read latency: 1 cycle, `SelKey` at edge n → `RoundKey` valid after edge n. The decryptor changes `SelKey` on its negative edge, which satisfies this.
- Restart from DONE: `KeyRy` falls after the accepting edge; old keys are unreadable from then on.
- Throughput: one schedule per 11 cycles, back-to-back if `Start` is held.

## Structure
- Shared package `aes_pkg`:
  - `AES_NR`=10
  - Rcon table as a function/constant array
  - FSM state encoding (2-bit)
  - `rot_word` function
  - The decryptor also imports `AES_NR` from it.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box, instantiated 4× for SubWord.
- Buffer: 11×128 register array; one write port, one read port.

## Test plan
- FIPS-197 A.1: `Key`=2b7e151628aed2a6abf7158809cf4f3c, pulse `Start` → `KeyRy` after 10 cycles; `SelKey`=1 → a0fafe1788542cb123a339392a6c7605; `SelKey`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6; `SelKey`=0 → the key itself.
- FIPS-197 C.1: `Key`=000102030405060708090a0b0c0d0e0f → `SelKey`=10 gives 13111d7fe3944a17f307a78b4d2b30c5. Sweep `SelKey` 10→0 on negedges, checking every value with 1-cycle latency.
- Out-of-range and not-ready reads: `SelKey`=11,15 → `RoundKey`=0. Any `SelKey` while `Busy`=1 → 0.
- `Start` pulsed again at E5 (mid-EXPAND) with a different key → ignored; A.1 keys result, `KeyRy` still at E0+10.
- Restart from DONE with the C.1 key → `KeyRy` drops next cycle and re-rises 10 cycles later with C.1 values.
- Assert `Rst` at E4 asynchronously (between edges) → `Busy`, `KeyRy`, `RoundKey` go to 0 immediately. A following `Start` yields a correct full schedule.
